// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch stage.
//   fetch_state_t : fetch controller states (IDLE, FETCH, HOLD, ERR)
//   FETCH_ADDR_W  : default PC / memory address width
//   FETCH_INSTR_W : default instruction word width
`timescale 1ns/1ps
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts FETCH cycles that pass without a memory ack.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at zero (asserted whenever not fetching)
//   cnt_en     : a FETCH cycle without ack, count it
//   expired    : this counted cycle is the TIMEOUT-th one; the controller
//                leaves for ERR at the coming edge
`timescale 1ns/1ps
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // The count holds how many ack-less cycles have already completed, so the
  // cycle that sees TIMEOUT-1 is the TIMEOUT-th one.
  assign expired = cnt_en && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage behind the R31 program counter.
// Issues one outstanding instruction-memory read at a time, captures the
// returned word into IR, pulses incr_pc to advance R31, and presents IR to
// decode with a valid/ready handshake. flush discards the in-flight or held
// instruction; stall blocks new launches only.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   R31                 : current program counter
//   start               : fetch enable (level)
//   stall               : blocks launch of a new fetch
//   flush               : redirect pulse, discards current/pending instruction
//   mem_rd_req/mem_addr : read request and its (held) address
//   mem_ack/mem_rdata   : read data valid / data
//   incr_pc             : one-cycle pulse advancing R31
//   IR/ir_valid/ir_ready: instruction register and decode handshake
//   fetch_err           : sticky fetch timeout
//
// Build option: define INSTR_FETCH_TIMEOUT_EN to add the FETCH timeout
// counter and the ERR state; otherwise FETCH waits forever, fetch_err = 0.
`timescale 1ns/1ps
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  R31,
  input  logic               start,
  input  logic               stall,
  input  logic               flush,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               incr_pc,
  output logic [INSTR_W-1:0] IR,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               fetch_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT must be at least 1");
  end

  fetch_state_t state_q, state_d;
  logic         discard_q, discard_d;
  logic         load_addr;
  logic         load_ir;
  logic         timeout_hit;

`ifdef INSTR_FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != FETCH),
    .cnt_en  ((state_q == FETCH) && !mem_ack),
    .expired (timeout_hit)
  );

  assign fetch_err = (state_q == ERR);
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // IR is only presented while holding, so valid is a pure state decode.
  assign ir_valid = (state_q == HOLD);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    load_addr  = 1'b0;
    load_ir    = 1'b0;
    mem_rd_req = 1'b0;
    incr_pc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stall && !flush) begin
          load_addr = 1'b1;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        // The request is never withdrawn: a flushed fetch still waits for its
        // ack so the memory never sees a second outstanding read.
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            load_ir = 1'b1;
            incr_pc = 1'b1;
            state_d = HOLD;
          end
        end else begin
          if (flush) begin
            discard_d = 1'b1;
          end
          if (timeout_hit) begin
            state_d = ERR;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (ir_ready) begin
          if (start && !stall) begin
            load_addr = 1'b1;  // R31 already advanced at the ack edge
            state_d   = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      ERR: begin
        // Parked until reset.
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      mem_addr  <= '0;
      IR        <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (load_addr) begin
        mem_addr <= R31;
      end
      if (load_ir) begin
        IR <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
// Includes a small R31 register model that loads on request and advances on
// incr_pc, plus a count of incr_pc pulses seen at clock edges.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] R31;
  logic        start;
  logic        stall;
  logic        flush;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        incr_pc;
  logic [31:0] IR;
  logic        ir_valid;
  logic        ir_ready;
  logic        fetch_err;

  logic        pc_set;
  logic [31:0] pc_set_val;
  int          incr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .R31        (R31),
    .start      (start),
    .stall      (stall),
    .flush      (flush),
    .mem_rd_req (mem_rd_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .incr_pc    (incr_pc),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: bench-controlled load, otherwise +1 per incr_pc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R31 <= '0;
    end else if (pc_set) begin
      R31 <= pc_set_val;
    end else if (incr_pc) begin
      R31 <= R31 + 32'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr_cnt <= 0;
    end else if (incr_pc) begin
      incr_cnt <= incr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] val);
    pc_set_val = val;
    pc_set     = 1'b1;
    tick();
    pc_set     = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    ir_ready   = 1'b0;
    pc_set     = 1'b0;
    pc_set_val = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_req",    mem_rd_req, 0);
    check("rst_incr_pc",   incr_pc,    0);
    check("rst_ir_valid",  ir_valid,   0);
    check("rst_fetch_err", fetch_err,  0);
    check("rst_ir",        IR,         0);
    check("rst_mem_addr",  mem_addr,   0);
    rst_n = 1'b1;
    tick();

    // ---- 1: zero-wait fetch from 0x10 ----
    set_pc(32'h10);
    start = 1'b1;
    tick();
    check("t1_rd_req", mem_rd_req, 1);
    check("t1_addr",   mem_addr,   32'h10);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_incr_pc", incr_pc, 1);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    check("t1_ir_valid",   ir_valid,   1);
    check("t1_ir",         IR,         32'hDEAD_BEEF);
    check("t1_incr_off",   incr_pc,    0);
    check("t1_rd_req_off", mem_rd_req, 0);
    check("t1_incr_cnt",   incr_cnt,   1);
    check("t1_r31",        R31,        32'h11);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    #1;
    check("t1_next_rd_req", mem_rd_req, 1);
    check("t1_next_addr",   mem_addr,   32'h11);
    check("t1_valid_drop",  ir_valid,   0);

    // ---- 2: ack delayed by 3 cycles ----
    for (int k = 0; k < 3; k++) begin
      check("t2_wait_rd_req", mem_rd_req, 1);
      check("t2_wait_addr",   mem_addr,   32'h11);
      check("t2_wait_incr",   incr_pc,    0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    check("t2_ack_rd_req", mem_rd_req, 1);
    check("t2_ack_addr",   mem_addr,   32'h11);
    check("t2_ack_incr",   incr_pc,    1);
    tick();
    mem_ack = 1'b0;
    #1;
    check("t2_ir",       IR,       32'h1234_5678);
    check("t2_ir_valid", ir_valid, 1);
    check("t2_incr_cnt", incr_cnt, 2);

    // ---- 3: decode back-pressure for 5 HOLD cycles, stray ack ignored ----
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      check("t3_hold_valid",  ir_valid,   1);
      check("t3_hold_ir",     IR,         32'h1234_5678);
      check("t3_hold_rd_req", mem_rd_req, 0);
      check("t3_hold_incr",   incr_pc,    0);
      tick();
    end
    mem_ack = 1'b0;
    check("t3_incr_cnt", incr_cnt, 2);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    #1;
    check("t3_refetch_rd_req", mem_rd_req, 1);
    check("t3_refetch_addr",   mem_addr,   32'h12);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack  = 1'b0;
    start    = 1'b0;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    #1;
    check("t3_idle_rd_req", mem_rd_req, 0);
    check("t3_idle_valid",  ir_valid,   0);
    check("t3_ir",          IR,         32'hCAFE_F00D);
    check("t3_r31",         R31,        32'h13);

    // ---- 4: flush in cycle 2 of a 4-cycle fetch ----
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t4_c1_rd_req", mem_rd_req, 1);
    check("t4_c1_addr",   mem_addr,   32'h13);
    tick();
    flush = 1'b1;
    #1;
    check("t4_c2_rd_req", mem_rd_req, 1);
    check("t4_c2_incr",   incr_pc,    0);
    tick();
    flush = 1'b0;
    #1;
    check("t4_c3_rd_req", mem_rd_req, 1);
    check("t4_c3_addr",   mem_addr,   32'h13);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    #1;
    check("t4_c4_rd_req", mem_rd_req, 1);
    check("t4_c4_incr",   incr_pc,    0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("t4_idle_rd_req", mem_rd_req, 0);
    check("t4_idle_valid",  ir_valid,   0);
    check("t4_ir_kept",     IR,         32'hCAFE_F00D);
    check("t4_incr_cnt",    incr_cnt,   3);
    check("t4_r31",         R31,        32'h13);

    // ---- 5a: start dropped mid-fetch completes; flush beats ir_ready ----
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t5_fetch_addr", mem_addr, 32'h13);
    tick();
    check("t5_no_abort", mem_rd_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_C0DE;
    tick();
    mem_ack = 1'b0;
    #1;
    check("t5_hold_valid", ir_valid, 1);
    check("t5_hold_ir",    IR,       32'h0BAD_C0DE);
    flush    = 1'b1;
    ir_ready = 1'b1;
    start    = 1'b1;
    tick();
    flush    = 1'b0;
    ir_ready = 1'b0;
    start    = 1'b0;
    #1;
    check("t5_flush_valid",  ir_valid,   0);
    check("t5_flush_rd_req", mem_rd_req, 0);
    tick();
    check("t5_flush_nofetch", mem_rd_req, 0);

    // ---- 5b: stall with ir_ready in HOLD goes idle ----
    start = 1'b1;
    tick();
    check("t5s_addr", mem_addr, 32'h14);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    tick();
    mem_ack  = 1'b0;
    stall    = 1'b1;
    ir_ready = 1'b1;
    #1;
    check("t5s_hold_valid", ir_valid, 1);
    tick();
    check("t5s_idle_valid",  ir_valid,   0);
    check("t5s_idle_rd_req", mem_rd_req, 0);
    tick();
    check("t5s_stall_block", mem_rd_req, 0);
    stall    = 1'b0;
    ir_ready = 1'b0;
    tick();
    check("t5s_resume_rd_req", mem_rd_req, 1);
    check("t5s_resume_addr",   mem_addr,   32'h15);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    check("t5s_ir",  IR,  32'h1111_2222);
    check("t5s_r31", R31, 32'h16);

    // ---- back-to-back: ir_ready and ack tied high, FETCH/HOLD alternate ----
    ir_ready  = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b_rd_req", mem_rd_req, (i % 2 == 0) ? 1 : 0);
    end
    check("b2b_incr_cnt", incr_cnt, 9);
    check("b2b_r31",      R31,      32'h19);
    check("b2b_ir",       IR,       32'hA5A5_A5A5);
    mem_ack = 1'b0;
    start   = 1'b0;
    tick();
    ir_ready = 1'b0;
    #1;
    check("b2b_idle_rd_req", mem_rd_req, 0);

    // ---- 6: memory never acks ----
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
`ifdef INSTR_FETCH_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      check("t6_wait_rd_req", mem_rd_req, 1);
      check("t6_wait_err",    fetch_err,  0);
      tick();
    end
    check("t6_err",        fetch_err,  1);
    check("t6_err_rd_req", mem_rd_req, 0);
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    check("t6_err_sticky",  fetch_err,  1);
    check("t6_rd_req_low",  mem_rd_req, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_err",    fetch_err,  0);
    check("t6_rst_rd_req", mem_rd_req, 0);
`else
    for (int k = 0; k < 20; k++) begin
      check("t6_wait_rd_req", mem_rd_req, 1);
      check("t6_wait_addr",   mem_addr,   32'h19);
      check("t6_wait_err",    fetch_err,  0);
      tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h600D_F00D;
    tick();
    mem_ack = 1'b0;
    #1;
    check("t6_ir",       IR,        32'h600D_F00D);
    check("t6_ir_valid", ir_valid,  1);
    check("t6_err",      fetch_err, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",    ir_valid,   0);
    check("arst_ir",       IR,         0);
    check("arst_mem_addr", mem_addr,   0);
    check("arst_rd_req",   mem_rd_req, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
